tx_packet_buf: RTL and testbench
================================

TX_PACKET_BUF -- requirements
Module: tx_packet_buf

Interface
REQ-001 Parameter DEPTH, default 64, sets the packet buffer size in bytes; legal values are powers of two from 4 to 128.
REQ-002 clk  input  1  single block clock; all state changes occur on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 len_wr_en  input  1  one-cycle strobe: write data_in to the length register.
REQ-005 pkt_wr_en  input  1  one-cycle strobe: append data_in to the buffer.
REQ-006 data_in  input  8  write data from the register wrapper.
REQ-007 len_data_out  output  8  current length register value.
REQ-008 stat_data_out  output  8  status byte: {busy, ovf, unf, 5'b0}.
REQ-009 stat_rd_en  input  1  one-cycle strobe: read status; clears ovf and unf on the following edge.
REQ-010 start  input  1  one-cycle request to transmit the buffered packet.
REQ-011 out_valid  output  1  a byte is presented to the downstream DAC/LVDS stage.
REQ-012 out_ready  input  1  downstream accepts out_data when out_valid is also high.
REQ-013 out_data  output  8  packet byte.
REQ-014 out_last  output  1  high with the final byte of the packet.
REQ-015 busy  output  1  high while in the SEND state.

Function
REQ-016 The FSM SHALL have two states: IDLE and SEND.
REQ-017 In IDLE, a len_wr_en write SHALL store min(data_in, DEPTH); a value of 0 SHALL be stored as 0.
REQ-018 In IDLE, pkt_wr_en SHALL write the byte at wr_ptr and increment count, provided count < DEPTH and start is not accepted in the same cycle.
REQ-019 A pkt_wr_en that is dropped (buffer full, state SEND, or same cycle as an accepted start) SHALL set the sticky flag ovf.
REQ-020 In IDLE, start SHALL be accepted only when len != 0 and count >= len, and acceptance SHALL move the FSM to SEND on the next edge.
REQ-021 A start that is not accepted SHALL set the sticky flag unf and leave the FSM in IDLE.
REQ-022 The first out_valid SHALL assert one cycle after the edge that samples the accepted start, with out_data equal to buffer byte 0.
REQ-023 A transfer SHALL occur on every edge where out_valid and out_ready are both high; the next byte SHALL be presented on the following cycle, sustaining one byte per cycle.
REQ-024 While out_valid is high and out_ready is low, out_data and out_last SHALL hold stable.
REQ-025 out_last SHALL be high exactly when out_valid is high and the byte index equals len-1.
REQ-026 After the last transfer, the FSM SHALL return to IDLE: out_valid low and busy low on the next cycle.
REQ-027 len_wr_en in SEND SHALL be ignored without setting any flag.
REQ-028 start in SEND SHALL be ignored without setting any flag.
REQ-029 When stat_rd_en and a flag-setting event occur in the same cycle, the set SHALL win.
REQ-030 Byte indices and wr_ptr SHALL be log2(DEPTH) bits wide.
REQ-031 count SHALL be log2(DEPTH)+1 bits wide so that a full buffer (count = DEPTH) is representable.

Reset
REQ-032 reset_n low SHALL immediately force state IDLE and set out_valid, out_last, busy, ovf, unf to 0.
REQ-033 reset_n low SHALL also set len, count, wr_ptr and the read index to 0.
REQ-034 Reset during SEND SHALL abort the packet, with no further out_valid until a new start is accepted.
REQ-035 Buffer contents need not be cleared by reset.

Configuration
REQ-036 Macro TX_PKT_REPLAY_EN.
REQ-037 With TX_PKT_REPLAY_EN defined, count and wr_ptr SHALL be kept after SEND, so that a later start retransmits the same packet.
REQ-038 Without TX_PKT_REPLAY_EN, count and wr_ptr SHALL clear to 0 when the FSM returns to IDLE.

Verification
REQ-039 Write len=4, write bytes A1 A2 A3 A4, start with out_ready=1 -> out_data A1..A4 on 4 consecutive cycles; out_last on A4; busy low afterwards.
REQ-040 Same packet with out_ready toggling 1,0,0,1,... -> each byte held stable while stalled; 4 transfers total; no duplicates.
REQ-041 Write len=5, write 3 bytes, start -> no out_valid; status read = 0x20; the following status read = 0x00.
REQ-042 DEPTH=64: write 65 bytes -> count=64 and ovf=1; a write during SEND also sets ovf.
REQ-043 Assert reset_n low mid-SEND after 2 of 4 bytes -> outputs zero immediately; after release, start yields no out_valid (unf=1).
REQ-044 With TX_PKT_REPLAY_EN defined: send a 4-byte packet, then start again -> identical 4 bytes. Without it: the second start sets unf.

Source files
------------

// File: rtl/tx_packet_buf_if.sv
// ---------------------------------------------------------------------------
// tx_packet_buf_if
// Bundles the register-wrapper strobes and the downstream byte stream of
// tx_packet_buf into one port.
//
//   len_wr_en      strobe: write data_in to the length register
//   pkt_wr_en      strobe: append data_in to the packet buffer
//   data_in  [7:0] write data from the register wrapper
//   stat_rd_en     strobe: read status (clears ovf/unf on the next edge)
//   start          request to transmit the buffered packet
//   len_data_out   current length register value
//   stat_data_out  {busy, ovf, unf, 5'b0}
//   out_valid      byte presented downstream
//   out_ready      downstream accepts the byte
//   out_data [7:0] packet byte
//   out_last       final byte of the packet
//   busy           block is transmitting
//
// master: register wrapper + downstream sink side; slave: tx_packet_buf.
// ---------------------------------------------------------------------------
interface tx_packet_buf_if;
    logic       len_wr_en;
    logic       pkt_wr_en;
    logic [7:0] data_in;
    logic       stat_rd_en;
    logic       start;
    logic [7:0] len_data_out;
    logic [7:0] stat_data_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;

    modport master (
        output len_wr_en, pkt_wr_en, data_in, stat_rd_en, start, out_ready,
        input  len_data_out, stat_data_out, out_valid, out_data, out_last, busy
    );

    modport slave (
        input  len_wr_en, pkt_wr_en, data_in, stat_rd_en, start, out_ready,
        output len_data_out, stat_data_out, out_valid, out_data, out_last, busy
    );
endinterface

// File: rtl/tx_packet_buf.sv
// ---------------------------------------------------------------------------
// tx_packet_buf
// Byte packet buffer for the DAC/LVDS transmit path. The register wrapper
// loads a length and appends bytes; start replays bytes 0..len-1 onto a
// valid/ready stream, one byte per cycle when the sink is ready.
//
// Ports:
//   clk      block clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      tx_packet_buf_if.slave (register strobes, status, byte stream)
//
// Parameter:
//   DEPTH    buffer size in bytes, power of two, 4..128
//
// Build option:
//   TX_PKT_REPLAY_EN  when defined, count/wr_ptr survive a transmission so a
//                     later start resends the same packet; otherwise the
//                     buffer empties when the packet completes.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | accepting length/byte writes, waiting for a valid start
// SEND  | presenting bytes 0..len-1 downstream, busy high
// ---------------------------------------------------------------------------
module tx_packet_buf #(
    parameter int DEPTH = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    tx_packet_buf_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [7:0]    DEPTH_LEN = 8'(DEPTH);
    localparam logic [AW-1:0] ONE_IDX   = 1;
    localparam logic [AW:0]   ONE_CNT   = 1;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      len_q, len_d;
    logic [AW:0]     count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_idx_q, rd_idx_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic [7:0]      out_data_q, out_data_d;
    logic            busy_q, busy_d;

    logic [7:0]      mem [DEPTH];

    logic            start_ok;
    logic            start_acc;
    logic            pkt_acc;
    logic            ovf_set;
    logic            unf_set;
    logic [7:0]      count_b;
    logic [AW-1:0]   next_idx;
    logic            next_is_last;

    // len never exceeds DEPTH (<= 128), so an 8-bit compare is exact.
    assign count_b      = 8'(count_q);
    assign start_ok     = (len_q != 8'd0) && (count_b >= len_q);
    assign start_acc    = (state_q == IDLE) && bus.start && start_ok;
    assign next_idx     = rd_idx_q + ONE_IDX;
    assign next_is_last = (8'(next_idx) == (len_q - 8'd1));

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_idx_d    = rd_idx_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        busy_d      = busy_q;
        pkt_acc     = 1'b0;
        ovf_set     = 1'b0;
        unf_set     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.len_wr_en) begin
                    len_d = (bus.data_in > DEPTH_LEN) ? DEPTH_LEN : bus.data_in;
                end

                if (bus.start) begin
                    if (start_ok) begin
                        // First byte is loaded on the accepting edge so it is
                        // on the bus together with the first out_valid.
                        state_d     = SEND;
                        busy_d      = 1'b1;
                        out_valid_d = 1'b1;
                        rd_idx_d    = '0;
                        out_data_d  = mem[0];
                        out_last_d  = (len_q == 8'd1);
                    end else begin
                        unf_set = 1'b1;
                    end
                end

                if (bus.pkt_wr_en) begin
                    // A write racing an accepted start would land behind the
                    // packet being sent; drop it and flag it instead.
                    if ((count_q < DEPTH_CNT) && !start_acc) begin
                        pkt_acc  = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_IDX;
                        count_d  = count_q + ONE_CNT;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end

            SEND: begin
                if (bus.pkt_wr_en) begin
                    ovf_set = 1'b1;
                end

                if (out_valid_q && bus.out_ready) begin
                    if (out_last_q) begin
                        state_d     = IDLE;
                        busy_d      = 1'b0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
`ifndef TX_PKT_REPLAY_EN
                        count_d     = '0;
                        wr_ptr_d    = '0;
`endif
                    end else begin
                        rd_idx_d    = next_idx;
                        out_data_d  = mem[next_idx];
                        out_last_d  = next_is_last;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A flag-setting event in the read cycle survives the read-clear.
        ovf_d = ovf_set | (ovf_q & ~bus.stat_rd_en);
        unf_d = unf_set | (unf_q & ~bus.stat_rd_en);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_idx_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_idx_q    <= rd_idx_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
        end
    end

    // Buffer storage is not reset; only bytes below count are ever read.
    always_ff @(posedge clk) begin
        if (pkt_acc) begin
            mem[wr_ptr_q] <= bus.data_in;
        end
    end

    assign bus.len_data_out  = len_q;
    assign bus.stat_data_out = {busy_q, ovf_q, unf_q, 5'b0};
    assign bus.out_valid     = out_valid_q;
    assign bus.out_last      = out_last_q;
    assign bus.out_data      = out_data_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_tx_packet_buf.sv
// ---------------------------------------------------------------------------
// tb_tx_packet_buf
// Drives tx_packet_buf through directed packet scenarios and a randomized
// operation mix, comparing against a byte-queue reference model.
// Honours TX_PKT_REPLAY_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_tx_packet_buf;

    localparam int DEPTH = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    tx_packet_buf_if bus();

    tx_packet_buf #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // reference model: buffered bytes, length, sticky flags
    logic [7:0] m_buf [DEPTH];
    int         m_count;
    int         m_len;
    bit         m_ovf;
    bit         m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] m_stat(input bit b);
        return {b, m_ovf, m_unf, 5'b0};
    endfunction

    task automatic clear_strobes();
        bus.len_wr_en  = 1'b0;
        bus.pkt_wr_en  = 1'b0;
        bus.stat_rd_en = 1'b0;
        bus.start      = 1'b0;
    endtask

    // Called at a negedge; asserts reset between edges and checks outputs
    // drop without waiting for a clock.
    task automatic do_reset();
        clear_strobes();
        bus.out_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check("rst_valid", bus.out_valid, 0);
        check("rst_last",  bus.out_last, 0);
        check("rst_busy",  bus.busy, 0);
        check("rst_stat",  bus.stat_data_out, 8'h00);
        check("rst_len",   bus.len_data_out, 8'h00);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_count = 0;
        m_len   = 0;
        m_ovf   = 0;
        m_unf   = 0;
    endtask

    // Stream the packet out of SEND. mode: 0 ready always, 1 ready 1,0,0,..,
    // 2 random. inj: 0 none, 1 random writes/starts while busy, 2 one byte
    // write on the first SEND cycle. stop: number of transfers to take.
    task automatic drain(input int mode, input int stop, input int inj);
        int idx = 0;
        int k = 0;
        bit rdy, p, l, s;
        while (idx < stop && k < 4*DEPTH + 20) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (k % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            p = (inj == 1) ? ($urandom_range(0, 7) == 0) : (inj == 2 && k == 0);
            l = (inj == 1) && ($urandom_range(0, 7) == 0);
            s = (inj == 1) && ($urandom_range(0, 7) == 0);
            bus.out_ready = rdy;
            bus.pkt_wr_en = p;
            bus.len_wr_en = l;
            bus.start     = s;
            bus.data_in   = 8'($urandom);
            check("snd_valid", bus.out_valid, 1);
            check("snd_busy",  bus.busy, 1);
            check("snd_data",  bus.out_data, m_buf[idx]);
            check("snd_last",  bus.out_last, (idx == m_len - 1));
            @(negedge clk);
            clear_strobes();
            if (p) m_ovf = 1;
            if (rdy) idx++;
            k++;
        end
        bus.out_ready = 1'b0;
        check("snd_count", idx, stop);
        if (stop == m_len) begin
            check("end_valid", bus.out_valid, 0);
            check("end_busy",  bus.busy, 0);
            check("end_last",  bus.out_last, 0);
            check("end_stat",  bus.stat_data_out, m_stat(0));
`ifndef TX_PKT_REPLAY_EN
            m_count = 0;
`endif
        end
    endtask

    // One IDLE-state cycle with any mix of strobes; starts a drain if the
    // model says the start is accepted. stop=0 means the whole packet.
    task automatic op(input bit lw, input bit pw, input bit sr, input bit st,
                      input logic [7:0] d, input int mode, input int stop, input int inj);
        bit acc, oset;
        acc  = st && (m_len != 0) && (m_count >= m_len);
        oset = 0;
        bus.len_wr_en  = lw;
        bus.pkt_wr_en  = pw;
        bus.stat_rd_en = sr;
        bus.start      = st;
        bus.data_in    = d;
        if (sr) check("stat_rd", bus.stat_data_out, m_stat(0));
        @(negedge clk);
        clear_strobes();
        if (lw) m_len = (d > DEPTH) ? DEPTH : int'(d);
        if (pw) begin
            if (!acc && m_count < DEPTH) begin
                m_buf[m_count] = d;
                m_count++;
            end else begin
                oset = 1;
            end
        end
        if (sr) begin
            m_ovf = 0;
            m_unf = 0;
        end
        if (oset) m_ovf = 1;
        if (st && !acc) m_unf = 1;
        if (lw) check("len_val", bus.len_data_out, m_len);
        if (acc) begin
            drain(mode, (stop == 0) ? m_len : stop, inj);
        end else begin
            check("idle_valid", bus.out_valid, 0);
            check("idle_busy",  bus.busy, 0);
        end
    endtask

    task automatic wr_len(input logic [7:0] v);  op(1, 0, 0, 0, v, 0, 0, 0); endtask
    task automatic wr_byte(input logic [7:0] v); op(0, 1, 0, 0, v, 0, 0, 0); endtask
    task automatic rd_stat();                    op(0, 0, 1, 0, 8'h00, 0, 0, 0); endtask

    initial begin
        logic [7:0] pkt [4];
        int r;
        pkt[0] = 8'hA1; pkt[1] = 8'hA2; pkt[2] = 8'hA3; pkt[3] = 8'hA4;
        clear_strobes();
        bus.data_in   = 8'h00;
        bus.out_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // 4-byte packet, sink always ready
        wr_len(8'd4);
        for (int i = 0; i < 4; i++) wr_byte(pkt[i]);
        op(0, 0, 0, 1, 8'h00, 0, 0, 0);

        // same packet with stalls
        for (int i = 0; i < 4; i++) wr_byte(pkt[i]);
        op(0, 0, 0, 1, 8'h00, 1, 0, 0);

        // second start: replay resends, otherwise underflow
        op(0, 0, 0, 1, 8'h00, 0, 0, 0);
        check("replay_stat", bus.stat_data_out,
`ifdef TX_PKT_REPLAY_EN
              8'h00
`else
              8'h20
`endif
        );
        rd_stat();

        // start with too few bytes
        do_reset();
        wr_len(8'd5);
        for (int i = 0; i < 3; i++) wr_byte(8'($urandom));
        op(0, 0, 0, 1, 8'h00, 0, 0, 0);
        check("unf_stat", bus.stat_data_out, 8'h20);
        rd_stat();
        check("unf_clr", bus.stat_data_out, 8'h00);
        rd_stat();

        // overflow on the 65th byte, then a write while sending
        do_reset();
        for (int i = 0; i < DEPTH + 1; i++) wr_byte(8'($urandom));
        check("ovf_stat", bus.stat_data_out, 8'h40);
        rd_stat();
        wr_len(8'd200);
        check("len_clamp", bus.len_data_out, DEPTH);
        op(0, 0, 0, 1, 8'h00, 2, 0, 2);
        check("ovf_send", bus.stat_data_out, 8'h40);
        rd_stat();

        // set wins over read-clear; start and write in the same cycle
        do_reset();
        op(0, 0, 1, 1, 8'h00, 0, 0, 0);
        check("set_wins", bus.stat_data_out, 8'h20);
        rd_stat();
        wr_len(8'd2);
        wr_byte(8'h11);
        wr_byte(8'h22);
        op(0, 1, 0, 1, 8'h33, 0, 0, 0);
        check("st_wr_ovf", bus.stat_data_out, 8'h40);
        rd_stat();
        wr_len(8'd0);
        op(0, 0, 0, 1, 8'h00, 0, 0, 0);
        check("len0_unf", bus.stat_data_out, 8'h20);

        // reset mid-packet
        do_reset();
        wr_len(8'd4);
        for (int i = 0; i < 4; i++) wr_byte(pkt[i]);
        op(0, 0, 0, 1, 8'h00, 0, 2, 0);
        do_reset();
        op(0, 0, 0, 1, 8'h00, 0, 0, 0);
        check("post_rst_unf", bus.stat_data_out, 8'h20);
        rd_stat();

        // randomized operation mix
        for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50)       op(0, 1, 0, 0, 8'($urandom), 2, 0, 1);
            else if (r < 60)  op(1, 0, 0, 0, ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                             : 8'($urandom_range(0, 12)), 2, 0, 1);
            else if (r < 70)  op(0, 0, 1, 0, 8'h00, 2, 0, 1);
            else if (r < 85)  op(0, 0, 0, 1, 8'h00, 2, 0, 1);
            else if (r < 90)  op(0, 1, 0, 1, 8'($urandom), 2, 0, 1);
            else if (r < 95)  op(0, 0, 1, 1, 8'h00, 2, 0, 1);
            else if (r < 98)  op(1, 1, 1, 0, 8'($urandom_range(0, 12)), 2, 0, 1);
            else              do_reset();
        end
        check("final_stat", bus.stat_data_out, m_stat(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
